// File: rtl/irrigation_pkg.sv
// Shared irrigation definitions: encoder codes, actuator FSM states and a
// saturating helper used by the run-time accumulator.
package irrigation_pkg;

  localparam logic [1:0] IRG_NONE      = 2'b00;
  localparam logic [1:0] IRG_SPRINKLER = 2'b01;
  localparam logic [1:0] IRG_DRIP      = 2'b10;
  localparam logic [1:0] IRG_INVALID   = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    LOCKOUT = 3'd4
  } irg_state_e;

  // True for the two codes that select a real zone valve.
  function automatic logic is_zone_code(input logic [1:0] code);
    return (code == IRG_SPRINKLER) || (code == IRG_DRIP);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/irrigation_actuator_ctrl_sec_timer.sv
// Second counter shared by all timed states. Counts tick pulses, can be
// cleared or frozen, and flags the tick on which the count reaches limit.
module sec_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       hold,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] sec_cnt;

  // Clear dominates; otherwise advance one step per unheld tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= 8'd0;
    end else if (clr) begin
      sec_cnt <= 8'd0;
    end else if (tick && !hold) begin
      sec_cnt <= sec_cnt + 8'd1;
    end
  end

  // The limit-th tick seen in a state ends it, so a state lasts limit ticks.
  always_comb begin
    expired = tick && !hold && (sec_cnt == (limit - 8'd1));
  end

endmodule

// File: rtl/irrigation_actuator_ctrl.sv
// Zone valve / pump sequencer. Opens the selected valve before starting the
// pump, stops the pump before closing the valve, and enforces an off-time
// between runs. Alarm forces an immediate shutdown into lockout.
module irrigation_actuator_ctrl
  import irrigation_pkg::*;
#(
  parameter int VALVE_SETTLE_S = 2,
  parameter int PUMP_STOP_S    = 3,
  parameter int MIN_OFF_S      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1s,
  input  logic [1:0]  coded_irg,
  input  logic        alarm,
  output logic        valve_sprinkler,
  output logic        valve_drip,
  output logic        pump_on,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state_o,
  output logic [15:0] runtime_s
);

  if (VALVE_SETTLE_S < 1 || VALVE_SETTLE_S > 255) begin : g_bad_settle
    $error("VALVE_SETTLE_S must be in 1..255");
  end
  if (PUMP_STOP_S < 1 || PUMP_STOP_S > 255) begin : g_bad_stop
    $error("PUMP_STOP_S must be in 1..255");
  end
  if (MIN_OFF_S < 1 || MIN_OFF_S > 255) begin : g_bad_off
    $error("MIN_OFF_S must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LIM = 8'(VALVE_SETTLE_S);
  localparam logic [7:0] DRAIN_LIM  = 8'(PUMP_STOP_S);
  localparam logic [7:0] OFF_LIM    = 8'(MIN_OFF_S);

  irg_state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] tmr_limit;
  logic       tmr_hold;
  logic       tmr_clr;
  logic       tmr_expired;
  logic       valve_open_d;

  // Pick the expiry limit belonging to the current timed state.
  always_comb begin
    tmr_limit = 8'd1;
    unique case (state_q)
      SETTLE:  tmr_limit = SETTLE_LIM;
      DRAIN:   tmr_limit = DRAIN_LIM;
      LOCKOUT: tmr_limit = OFF_LIM;
      default: tmr_limit = 8'd1;
    endcase
  end

  // Lockout does not age while the alarm is still present; every state
  // entry restarts the count so an entry-cycle tick is not credited.
  always_comb begin
    tmr_hold = (state_q == LOCKOUT) && alarm;
    tmr_clr  = (state_d != state_q) || tmr_hold;
  end

  sec_timer u_sec_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .hold    (tmr_hold),
    .tick    (tick_1s),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // Next-state logic; priority is alarm, then request change, then expiry.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (alarm) begin
      state_d = LOCKOUT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_zone_code(coded_irg)) begin
            state_d = SETTLE;
            mode_d  = coded_irg;
          end
        end
        SETTLE: begin
          if (coded_irg != mode_q)  state_d = DRAIN;
          else if (tmr_expired)     state_d = RUN;
        end
        RUN: begin
          if (coded_irg != mode_q)  state_d = DRAIN;
        end
        DRAIN: begin
          if (tmr_expired)          state_d = LOCKOUT;
        end
        LOCKOUT: begin
          if (tmr_expired)          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched zone register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= IRG_NONE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // A valve is open while settling, running or draining.
  always_comb begin
    valve_open_d = (state_d == SETTLE) || (state_d == RUN) || (state_d == DRAIN);
  end

  // Registered output decode from the next state so outputs track the edge
  // on which the state changes, with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_sprinkler <= 1'b0;
      valve_drip      <= 1'b0;
      pump_on         <= 1'b0;
      busy            <= 1'b0;
      state_o         <= 3'd0;
    end else begin
      valve_sprinkler <= valve_open_d && (mode_d == IRG_SPRINKLER);
      valve_drip      <= valve_open_d && (mode_d == IRG_DRIP);
      pump_on         <= (state_d == RUN);
      busy            <= (state_d != IDLE);
      state_o         <= state_d;
    end
  end

  // Sticky fault on any invalid code; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (coded_irg == IRG_INVALID) begin
      fault <= 1'b1;
    end
  end

  // Run-time seconds: cleared when a run starts, held after it ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runtime_s <= 16'd0;
    end else if ((state_q == IDLE) && (state_d == SETTLE)) begin
      runtime_s <= 16'd0;
    end else if ((state_q == RUN) && tick_1s) begin
      runtime_s <= sat_inc16(runtime_s);
    end
  end

endmodule

// File: tb/tb_irrigation_actuator_ctrl.sv
// Directed bench for irrigation_actuator_ctrl with a queue-based scoreboard:
// expectations are pushed as stimulus is applied and popped against outputs.
module tb_irrigation_actuator_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick_1s;
  logic [1:0]  coded_irg;
  logic        alarm;
  logic        valve_sprinkler;
  logic        valve_drip;
  logic        pump_on;
  logic        busy;
  logic        fault;
  logic [2:0]  state_o;
  logic [15:0] runtime_s;

  irrigation_actuator_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick_1s         (tick_1s),
    .coded_irg       (coded_irg),
    .alarm           (alarm),
    .valve_sprinkler (valve_sprinkler),
    .valve_drip      (valve_drip),
    .pump_on         (pump_on),
    .busy            (busy),
    .fault           (fault),
    .state_o         (state_o),
    .runtime_s       (runtime_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty observed=%0h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_out(input string t, input logic vs, input logic vd,
                          input logic p, input logic b, input logic [2:0] st);
    push({t, ".vs"}, 32'(vs));
    push({t, ".vd"}, 32'(vd));
    push({t, ".pump"}, 32'(p));
    push({t, ".busy"}, 32'(b));
    push({t, ".state"}, 32'(st));
  endtask

  task automatic cmp_out();
    pop_cmp(32'(valve_sprinkler));
    pop_cmp(32'(valve_drip));
    pop_cmp(32'(pump_on));
    pop_cmp(32'(busy));
    pop_cmp(32'(state_o));
  endtask

  // One clock; sample 1 time unit after the edge and check valve exclusivity.
  task automatic step();
    @(posedge clk);
    #1;
    n_checks++;
    assert (!(valve_sprinkler && valve_drip)) else begin
      n_err++;
      $error("FAIL valve_excl observed=%b%b required=not both", valve_sprinkler, valve_drip);
    end
  endtask

  // One second: a tick cycle followed by a quiet cycle.
  task automatic sec();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) sec();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    tick_1s   = 1'b0;
    coded_irg = 2'b00;
    alarm     = 1'b0;
    step();
    step();

    // Reset state
    push_out("rst", 0, 0, 0, 0, 3'd0);
    push("rst.runtime", 32'd0);
    push("rst.fault", 32'd0);
    cmp_out();
    pop_cmp(32'(runtime_s));
    pop_cmp(32'(fault));

    // First request honoured on the first edge after release
    rst_n     = 1'b1;
    coded_irg = 2'b01;
    push_out("first_req", 1, 0, 0, 1, 3'd1);
    step();
    cmp_out();

    // Normal sprinkler run
    push_out("settle_t1", 1, 0, 0, 1, 3'd1);
    sec();
    cmp_out();
    push_out("run_entry", 1, 0, 1, 1, 3'd2);
    sec();
    cmp_out();
    push("run_rt0", 32'd0);
    pop_cmp(32'(runtime_s));
    secs(10);
    push("run_rt10", 32'd10);
    pop_cmp(32'(runtime_s));
    coded_irg = 2'b00;
    push_out("stop_drain", 1, 0, 0, 1, 3'd3);
    step();
    cmp_out();
    secs(2);
    push_out("drain_t2", 1, 0, 0, 1, 3'd3);
    cmp_out();
    sec();
    push_out("drain_done", 0, 0, 0, 1, 3'd4);
    cmp_out();
    push("rt_hold", 32'd10);
    pop_cmp(32'(runtime_s));
    secs(4);
    push_out("lock_t4", 0, 0, 0, 1, 3'd4);
    cmp_out();
    sec();
    push_out("lock_done", 0, 0, 0, 0, 3'd0);
    cmp_out();

    // Mode switch in RUN
    coded_irg = 2'b01;
    step();
    secs(2);
    secs(3);
    push_out("sw_run", 1, 0, 1, 1, 3'd2);
    push("sw_rt3", 32'd3);
    cmp_out();
    pop_cmp(32'(runtime_s));
    coded_irg = 2'b10;
    push_out("sw_drain", 1, 0, 0, 1, 3'd3);
    step();
    cmp_out();
    secs(3);
    push_out("sw_lock", 0, 0, 0, 1, 3'd4);
    cmp_out();
    secs(4);
    tick_1s = 1'b1;
    push_out("sw_idle", 0, 0, 0, 0, 3'd0);
    step();
    cmp_out();
    tick_1s = 1'b0;
    push_out("sw_drip_open", 0, 1, 0, 1, 3'd1);
    push("sw_rt_clr", 32'd0);
    step();
    cmp_out();
    pop_cmp(32'(runtime_s));

    // Alarm in RUN
    secs(2);
    push_out("al_run", 0, 1, 1, 1, 3'd2);
    cmp_out();
    alarm = 1'b1;
    push_out("al_trip", 0, 0, 0, 1, 3'd4);
    step();
    cmp_out();
    secs(20);
    push_out("al_hold20", 0, 0, 0, 1, 3'd4);
    cmp_out();
    alarm     = 1'b0;
    coded_irg = 2'b00;
    secs(4);
    push_out("al_rel_t4", 0, 0, 0, 1, 3'd4);
    cmp_out();
    tick_1s = 1'b1;
    push_out("al_rel_t5", 0, 0, 0, 0, 3'd0);
    step();
    cmp_out();
    tick_1s = 1'b0;

    // Invalid code in IDLE
    push("inv_pre_fault", 32'd0);
    pop_cmp(32'(fault));
    coded_irg = 2'b11;
    push_out("inv_idle", 0, 0, 0, 0, 3'd0);
    push("inv_fault", 32'd1);
    step();
    cmp_out();
    pop_cmp(32'(fault));
    coded_irg = 2'b00;
    push("inv_fault_sticky", 32'd1);
    step();
    pop_cmp(32'(fault));

    // Invalid code in RUN
    coded_irg = 2'b01;
    step();
    secs(2);
    coded_irg = 2'b11;
    push_out("inv_run_drain", 1, 0, 0, 1, 3'd3);
    step();
    cmp_out();
    coded_irg = 2'b00;
    secs(3);
    push_out("inv_lock", 0, 0, 0, 1, 3'd4);
    cmp_out();
    secs(5);
    push_out("inv_idle2", 0, 0, 0, 0, 3'd0);
    push("inv_fault_end", 32'd1);
    cmp_out();
    pop_cmp(32'(fault));

    // Coincident expiry and request drop in SETTLE
    coded_irg = 2'b01;
    step();
    sec();
    tick_1s   = 1'b1;
    coded_irg = 2'b00;
    push_out("coinc_drain", 1, 0, 0, 1, 3'd3);
    step();
    cmp_out();
    tick_1s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sec();
      push("coinc_pump", 32'd0);
      pop_cmp(32'(pump_on));
    end
    push_out("coinc_lock", 0, 0, 0, 1, 3'd4);
    cmp_out();
    secs(5);

    // Asynchronous reset mid-run
    coded_irg = 2'b01;
    step();
    secs(3);
    push_out("ar_run", 1, 0, 1, 1, 3'd2);
    push("ar_rt1", 32'd1);
    cmp_out();
    pop_cmp(32'(runtime_s));
    #3;
    rst_n = 1'b0;
    #1;
    push_out("ar_async", 0, 0, 0, 0, 3'd0);
    push("ar_rt", 32'd0);
    push("ar_fault", 32'd0);
    cmp_out();
    pop_cmp(32'(runtime_s));
    pop_cmp(32'(fault));
    #1;
    rst_n = 1'b1;
    push_out("ar_restart", 1, 0, 0, 1, 3'd1);
    step();
    cmp_out();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
